// File: rtl/etch_win_ctrl_if.sv
//------------------------------------------------------------------------------
// etch_win_ctrl_if : video-in / line-buffer / window-out signal bundle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface etch_win_ctrl_if;
  logic        i_vs;
  logic        i_de;
  logic        lb_we;
  logic        lb_rd;
  logic        o_de;
  logic [10:0] o_x;
  logic [10:0] o_y;
  logic        o_border;
  logic        o_frame_done;
  logic        o_busy;
  logic        o_err;

  // master: pixel source / window consumer; slave: the window controller
  modport master (
    output i_vs, i_de,
    input  lb_we, lb_rd, o_de, o_x, o_y, o_border, o_frame_done, o_busy, o_err
  );

  modport slave (
    input  i_vs, i_de,
    output lb_we, lb_rd, o_de, o_x, o_y, o_border, o_frame_done, o_busy, o_err
  );
endinterface

`default_nettype wire

// File: rtl/etch_win_ctrl.sv
//------------------------------------------------------------------------------
// etch_win_ctrl : line-buffer sequencing and window-position control for a
//                 3-line erosion kernel (prime row 0, run rows, flush last row)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module etch_win_ctrl #(
  parameter int IMG_WIDTH_LINE = 800,
  parameter int IMG_HEIGHT     = 600
) (
  input  logic            clk,
  input  logic            reset_n,
  etch_win_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [10:0] c_x_last = 11'(IMG_WIDTH_LINE - 1);
  localparam logic [10:0] c_y_last = 11'(IMG_HEIGHT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [10:0] r_in_x;
  logic [10:0] r_in_y;
  logic [10:0] w_in_x_nxt;
  logic [10:0] w_in_y_nxt;

  logic        w_out_v;
  logic [10:0] w_out_x;
  logic [10:0] w_out_y;
  logic        w_err_set;
  logic        w_err_clr;
  logic        w_lb_we;
  logic        w_lb_rd;

  logic        r_de;
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic        r_border;
  logic        r_done;
  logic        r_err;

  //----------------------------------------------------------------------------
  // State register
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //----------------------------------------------------------------------------
  // Next state, counter updates and line-buffer strobes
  //----------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_in_x_nxt  = r_in_x;
    w_in_y_nxt  = r_in_y;
    w_out_v     = 1'b0;
    w_out_x     = r_in_x;
    w_out_y     = r_in_y - 11'd1;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;
    w_lb_we     = 1'b0;
    w_lb_rd     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.i_vs) begin
          w_state_nxt = ST_PRIME;
          w_in_x_nxt  = 11'd0;
          w_in_y_nxt  = 11'd0;
          w_err_clr   = 1'b1;
        end
      end

      ST_PRIME: begin
        if (bus.i_vs) begin
          w_state_nxt = ST_PRIME;
          w_in_x_nxt  = 11'd0;
          w_in_y_nxt  = 11'd0;
          w_err_set   = 1'b1;
        end else begin
          w_lb_we = bus.i_de;
          if (bus.i_de) begin
            if (r_in_x == c_x_last) begin
              w_in_x_nxt  = 11'd0;
              w_in_y_nxt  = r_in_y + 11'd1;
              w_state_nxt = ST_RUN;
            end else begin
              w_in_x_nxt = r_in_x + 11'd1;
            end
          end
        end
      end

      ST_RUN: begin
        if (bus.i_vs) begin
          w_state_nxt = ST_PRIME;
          w_in_x_nxt  = 11'd0;
          w_in_y_nxt  = 11'd0;
          w_err_set   = 1'b1;
        end else begin
          // window row lags the input row by one: the line buffer holds row-1
          w_lb_we = bus.i_de;
          w_lb_rd = bus.i_de;
          w_out_v = bus.i_de;
          if (bus.i_de) begin
            if (r_in_x == c_x_last) begin
              w_in_x_nxt = 11'd0;
              if (r_in_y == c_y_last) begin
                w_in_y_nxt  = 11'd0;
                w_state_nxt = ST_FLUSH;
              end else begin
                w_in_y_nxt = r_in_y + 11'd1;
              end
            end else begin
              w_in_x_nxt = r_in_x + 11'd1;
            end
          end
        end
      end

      ST_FLUSH: begin
        if (bus.i_vs) begin
          w_state_nxt = ST_PRIME;
          w_in_x_nxt  = 11'd0;
          w_in_y_nxt  = 11'd0;
          w_err_set   = 1'b1;
        end else begin
          // last row is drained from the line buffer; incoming pixels are illegal
          w_lb_rd   = 1'b1;
          w_out_v   = 1'b1;
          w_out_y   = c_y_last;
          w_err_set = bus.i_de;
          if (r_in_x == c_x_last) begin
            w_in_x_nxt  = 11'd0;
            w_state_nxt = ST_DONE;
          end else begin
            w_in_x_nxt = r_in_x + 11'd1;
          end
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  //----------------------------------------------------------------------------
  // Counters and registered window outputs
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_x   <= 11'd0;
      r_in_y   <= 11'd0;
      r_de     <= 1'b0;
      r_x      <= 11'd0;
      r_y      <= 11'd0;
      r_border <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_in_x   <= w_in_x_nxt;
      r_in_y   <= w_in_y_nxt;
      r_de     <= w_out_v;
      r_border <= w_out_v &&
                  ((w_out_x == 11'd0) || (w_out_x == c_x_last) ||
                   (w_out_y == 11'd0) || (w_out_y == c_y_last));
      if (w_out_v) begin
        r_x <= w_out_x;
        r_y <= w_out_y;
      end
      // DONE is entered on the edge that shows the last pixel, so the pulse trails it by one
      r_done <= (r_state == ST_DONE);
      if (w_err_clr) begin
        r_err <= 1'b0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.lb_we        = w_lb_we;
  assign bus.lb_rd        = w_lb_rd;
  assign bus.o_de         = r_de;
  assign bus.o_x          = r_x;
  assign bus.o_y          = r_y;
  assign bus.o_border     = r_border;
  assign bus.o_frame_done = r_done;
  assign bus.o_busy       = (r_state != ST_IDLE);
  assign bus.o_err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_etch_win_ctrl.sv
//------------------------------------------------------------------------------
// tb_etch_win_ctrl : directed self-checking bench for etch_win_ctrl (W=8, H=4)
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_etch_win_ctrl;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  etch_win_ctrl_if bus ();

  etch_win_ctrl #(
    .IMG_WIDTH_LINE (W),
    .IMG_HEIGHT     (H)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // output log, sampled on the falling edge
  int oq_x[$];
  int oq_y[$];
  int oq_b[$];
  int oq_c[$];
  int done_c[$];

  always @(negedge clk) begin
    if (bus.o_de) begin
      oq_x.push_back(int'(bus.o_x));
      oq_y.push_back(int'(bus.o_y));
      oq_b.push_back(int'(bus.o_border));
      oq_c.push_back(cyc);
    end
    if (bus.o_frame_done) done_c.push_back(cyc);
  end

  int n_chk = 0;
  int n_err = 0;
  int de_c[$];
  int obase;
  int dbase;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_vs(input logic de);
    bus.i_vs = 1'b1;
    bus.i_de = de;
    step();
    bus.i_vs = 1'b0;
    bus.i_de = 1'b0;
  endtask

  // drives npix pixels; gapped inserts (p%3)+1 idle cycles before each pixel
  task automatic send_pixels(input bit gapped, input int npix);
    for (int p = 0; p < npix; p++) begin
      if (gapped) begin
        for (int g = 0; g < (p % 3) + 1; g++) step();
      end
      if (p == W) chk("no_de_row0", 32'((oq_x.size() - obase) + int'(bus.o_de)), 32'd0);
      bus.i_de = 1'b1;
      if (p >= W) de_c.push_back(cyc);
      #1;
      if (p == 0) chk("lb_prime", 32'({bus.lb_we, bus.lb_rd}), 32'b10);
      if (p == W) chk("lb_run", 32'({bus.lb_we, bus.lb_rd}), 32'b11);
      step();
      bus.i_de = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_c.size() == dbase && n < 64) begin
      step();
      n++;
    end
    chk("done_seen", 32'(done_c.size() > dbase), 32'd1);
    step();
    step();
  endtask

  task automatic check_frame(input bit timing);
    int n;
    int interior;
    n        = oq_x.size() - obase;
    interior = 0;
    chk("de_count", 32'(n), 32'(NPIX));
    for (int i = 0; i < n && i < NPIX; i++) begin
      int ex;
      int ey;
      int eb;
      ex = i % W;
      ey = i / W;
      eb = (ex == 0 || ex == W - 1 || ey == 0 || ey == H - 1) ? 1 : 0;
      chk("pix_xy", 32'(oq_x[obase + i] * 256 + oq_y[obase + i]), 32'(ex * 256 + ey));
      chk("border", 32'(oq_b[obase + i]), 32'(eb));
      if (oq_b[obase + i] == 0) interior++;
      if (timing && i < (H - 1) * W && i < de_c.size())
        chk("de_latency", 32'(oq_c[obase + i] - de_c[i]), 32'd1);
    end
    chk("interior", 32'(interior), 32'd12);
    if (n >= NPIX)
      chk("flush_contig", 32'(oq_c[obase + NPIX - 1] - oq_c[obase + NPIX - W]), 32'(W - 1));
    chk("done_count", 32'(done_c.size() - dbase), 32'd1);
    if (done_c.size() > dbase && n > 0)
      chk("done_cyc", 32'(done_c[dbase] - oq_c[obase + n - 1]), 32'd1);
    chk("idle_after", 32'(bus.o_busy), 32'd0);
  endtask

  function automatic logic [28:0] all_out();
    return {bus.lb_we, bus.lb_rd, bus.o_de, bus.o_border, bus.o_frame_done,
            bus.o_busy, bus.o_err, bus.o_x, bus.o_y};
  endfunction

  initial begin
    int osz;
    bus.i_vs = 1'b0;
    bus.i_de = 1'b0;

    // reset state
    repeat (3) step();
    chk("reset_outs", 32'(all_out()), 32'd0);
    reset_n = 1'b1;
    step();
    chk("idle_busy", 32'(bus.o_busy), 32'd0);

    // continuous frame; i_de coincident with i_vs must be ignored
    obase = oq_x.size();
    dbase = done_c.size();
    de_c.delete();
    pulse_vs(1'b1);
    chk("busy_prime", 32'(bus.o_busy), 32'd1);
    send_pixels(1'b0, NPIX);
    wait_done();
    check_frame(1'b1);
    chk("err_clean", 32'(bus.o_err), 32'd0);

    // gapped frame
    obase = oq_x.size();
    dbase = done_c.size();
    de_c.delete();
    pulse_vs(1'b0);
    send_pixels(1'b1, NPIX);
    wait_done();
    check_frame(1'b1);

    // abort at in_y=2, in_x=5, then a full frame from PRIME
    dbase = done_c.size();
    obase = oq_x.size();
    pulse_vs(1'b0);
    send_pixels(1'b0, 2 * W + 5);
    pulse_vs(1'b1);
    chk("abort_err", 32'(bus.o_err), 32'd1);
    chk("abort_busy", 32'(bus.o_busy), 32'd1);
    chk("abort_de_off", 32'(bus.o_de), 32'd0);
    obase = oq_x.size();
    de_c.delete();
    send_pixels(1'b0, NPIX);
    wait_done();
    check_frame(1'b1);
    chk("abort_err_sticky", 32'(bus.o_err), 32'd1);

    // i_de during FLUSH
    obase = oq_x.size();
    dbase = done_c.size();
    de_c.delete();
    pulse_vs(1'b0);
    chk("err_cleared_vs", 32'(bus.o_err), 32'd0);
    send_pixels(1'b0, NPIX);
    for (int k = 0; k < 2; k++) begin
      bus.i_de = 1'b1;
      #1;
      chk("flush_lb", 32'({bus.lb_we, bus.lb_rd}), 32'b01);
      step();
    end
    bus.i_de = 1'b0;
    chk("flush_err", 32'(bus.o_err), 32'd1);
    wait_done();
    check_frame(1'b1);

    // asynchronous reset mid-frame at in_y=1 (with err set beforehand)
    obase = oq_x.size();
    pulse_vs(1'b0);
    pulse_vs(1'b0);
    chk("err_pre_reset", 32'(bus.o_err), 32'd1);
    send_pixels(1'b0, W + 2);
    bus.i_de = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    chk("reset_async", 32'(all_out()), 32'd0);
    step();
    step();
    chk("reset_hold", 32'(all_out()), 32'd0);
    reset_n = 1'b1;
    bus.i_de = 1'b0;
    step();
    osz = oq_x.size();
    for (int k = 0; k < 10; k++) begin
      bus.i_de = 1'b1;
      #1;
      chk("idle_no_we", 32'(bus.lb_we), 32'd0);
      step();
    end
    bus.i_de = 1'b0;
    step();
    chk("idle_no_de", 32'(oq_x.size() - osz), 32'd0);
    chk("idle_busy_end", 32'(bus.o_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_err);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/etch_win_ctrl.md
ETCH_WIN_CTRL -- requirements
Module: etch_win_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH_LINE, default 800, pixels per line (2..2047).
REQ-002 SHALL have parameter IMG_HEIGHT, default 600, lines per frame (2..2047).
REQ-003 clk  in  1  pixel clock; all logic rising-edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_vs  in  1  frame-start pulse, one cycle, precedes the first i_de of the frame.
REQ-006 i_de  in  1  input pixel valid; gaps allowed within and between lines.
REQ-007 lb_we  out  1  line-buffer write enable.
REQ-008 lb_rd  out  1  line-buffer read enable.
REQ-009 o_de  out  1  window-output valid, one cycle per output pixel.
REQ-010 o_x  out  11  column of the current output pixel.
REQ-011 o_y  out  11  row of the current output pixel.
REQ-012 o_border  out  1  output pixel is on the image edge; the erosion result SHALL be forced to 0 downstream.
REQ-013 o_frame_done  out  1  one-cycle pulse after the last output pixel of a frame.
REQ-014 o_busy  out  1  high in every state except IDLE.
REQ-015 o_err  out  1  sticky protocol-error flag; cleared only by reset or by i_vs in IDLE.

Function
REQ-016 FSM states SHALL be IDLE, PRIME, RUN, FLUSH, DONE.
REQ-017 IDLE: on i_vs go to PRIME; clear col/row counters; i_de in IDLE SHALL be ignored.
REQ-018 Input column counter in_x SHALL count i_de cycles 0..W-1 and wrap to 0 on the cycle after W-1; input row in_y SHALL increment on each wrap.
REQ-019 PRIME (in_y==0): lb_we=i_de, lb_rd=0, o_de=0; on the wrap of row 0 go to RUN.
REQ-020 RUN: lb_we=i_de, lb_rd=i_de (combinational, same cycle); o_de SHALL equal i_de delayed by 1 cycle, with o_x=in_x and o_y=in_y-1 registered on the same edge.
REQ-021 RUN: on the wrap of row H-1 go to FLUSH.
REQ-022 FLUSH: SHALL generate exactly W consecutive internal valid cycles with lb_rd=1, lb_we=0; o_de follows 1 cycle later with o_y=H-1, o_x=0..W-1; then go to DONE.
REQ-023 i_de asserted during FLUSH SHALL be ignored and SHALL set o_err.
REQ-024 DONE: o_frame_done=1 for exactly one cycle, then IDLE; total o_de count per frame SHALL be W*H.
REQ-025 o_border SHALL be 1 when o_de=1 and (o_x==0 or o_x==W-1 or o_y==0 or o_y==H-1); 0 whenever o_de=0.
REQ-026 i_vs in PRIME, RUN or FLUSH SHALL abort the frame: set o_err, clear counters, deassert o_de next cycle, enter PRIME; no o_frame_done for the aborted frame.
REQ-027 i_vs and i_de in the same cycle in IDLE: i_de SHALL be ignored.
REQ-028 Counters SHALL be 11 bits; no wrap past W-1 / H-1 permitted.

Reset
REQ-029 While reset_n=0: state=IDLE, counters=0, lb_we=lb_rd=o_de=o_border=o_frame_done=o_busy=o_err=0, o_x=o_y=0.
REQ-030 Reset asserted mid-frame SHALL take effect immediately (asynchronous); after release, the block SHALL wait in IDLE for the next i_vs.

Verification
REQ-031 W=8, H=4, i_vs then 32 continuous i_de -> 0 o_de during row 0; 24 o_de in RUN plus 8 in FLUSH = 32; o_frame_done one cycle after last o_de.
REQ-032 Same frame with i_de gaps of 1-3 cycles -> o_de sequence (o_x,o_y) identical to REQ-031, each o_de exactly 1 cycle after its i_de in RUN.
REQ-033 Check o_border -> high for all of o_y=0, o_y=3, o_x=0, o_x=7; exactly 12 interior pixels low.
REQ-034 i_vs injected at in_y=2, in_x=5 -> o_err=1, state PRIME, next frame completes normally with 32 o_de.
REQ-035 i_de pulsed during FLUSH -> o_err=1, lb_we stays 0, FLUSH still emits exactly 8 o_de.
REQ-036 reset_n low at in_y=1 for 2 cycles -> all outputs 0 immediately; i_de without i_vs produces no lb_we/o_de.
